// File: rtl/hex_probe_latch.sv
// Probe capture stage feeding the hex display decoders.
// Debounced key toggles live/frozen; a value match freezes automatically.
module hex_probe_latch #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] probe_in,
    input  logic             probe_valid,
    input  logic             match_en,
    input  logic [WIDTH-1:0] match_value,
    input  logic             key_n,
    output logic [WIDTH-1:0] nibbles,
    output logic             frozen,
    output logic             key_event
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        LIVE,
        FROZEN
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             stable_prev_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             event_q;
    logic             match_hit;

    assign match_hit = probe_valid & match_en & (probe_in == match_value);

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            LIVE: begin
                if (match_hit) begin
                    hold_d  = probe_in;
                    state_d = FROZEN;
                end else if (event_q) begin
                    state_d = FROZEN;
                end else if (probe_valid) begin
                    hold_d = probe_in;
                end
            end
            FROZEN: begin
                if (event_q) begin
                    state_d = LIVE;
                end
            end
            default: state_d = LIVE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            stable_q      <= 1'b1;
            stable_prev_q <= 1'b1;
            cnt_q         <= '0;
            event_q       <= 1'b0;
            state_q       <= LIVE;
            hold_q        <= '0;
        end else begin
            sync1_q       <= key_n;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
            event_q       <= stable_prev_q & ~stable_q;
            state_q       <= state_d;
            hold_q        <= hold_d;
        end
    end

    assign nibbles   = hold_q;
    assign frozen    = (state_q == FROZEN);
    assign key_event = event_q;

endmodule

// File: tb/tb_hex_probe_latch.sv
// Directed bench for hex_probe_latch with DEBOUNCE_CYCLES=8.
// Expected values are hand-derived constants.
module tb_hex_probe_latch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] probe_in;
    logic        probe_valid;
    logic        match_en;
    logic [15:0] match_value;
    logic        key_n;
    logic [15:0] nibbles;
    logic        frozen;
    logic        key_event;

    int checks = 0;
    int errors = 0;
    int events;

    hex_probe_latch #(
        .WIDTH(16),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .probe_in(probe_in),
        .probe_valid(probe_valid),
        .match_en(match_en),
        .match_value(match_value),
        .key_n(key_n),
        .nibbles(nibbles),
        .frozen(frozen),
        .key_event(key_event)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_release();
        key_n = 1'b0;
        ticks(12);
        key_n = 1'b1;
        ticks(14);
    endtask

    task automatic stream(input logic [15:0] v);
        probe_in    = v;
        probe_valid = 1'b1;
        tick();
    endtask

    initial begin
        reset_n     = 1'b0;
        probe_in    = '0;
        probe_valid = 1'b0;
        match_en    = 1'b0;
        match_value = '0;
        key_n       = 1'b1;
        #12;
        check("rst_nib", 32'(nibbles), 32'h0);
        check("rst_frz", 32'(frozen), 32'h0);
        check("rst_evt", 32'(key_event), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        stream(16'h12AB);
        check("live_load", 32'(nibbles), 32'h12AB);
        probe_in    = 16'h3456;
        probe_valid = 1'b0;
        tick();
        check("live_noval", 32'(nibbles), 32'h12AB);

        events = 0;
        for (int i = 0; i < 40; i++) begin
            key_n = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            events += int'(key_event);
        end
        key_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            events += int'(key_event);
        end
        check("bounce_evt", 32'(events), 32'h0);

        key_n  = 1'b0;
        events = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            events += int'(key_event);
        end
        check("deb_early", 32'(events), 32'h0);
        tick();
        check("deb_evt11", 32'(key_event), 32'h1);
        check("deb_frz_pre", 32'(frozen), 32'h0);
        tick();
        check("deb_evt_end", 32'(key_event), 32'h0);
        check("deb_frz", 32'(frozen), 32'h1);
        stream(16'hBEEF);
        check("frz_hold", 32'(nibbles), 32'h12AB);
        probe_valid = 1'b0;
        events = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            events += int'(key_event);
        end
        check("hold_one_evt", 32'(events), 32'h0);
        key_n = 1'b1;
        events = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            events += int'(key_event);
        end
        check("release_evt", 32'(events), 32'h0);
        check("release_frz", 32'(frozen), 32'h1);

        key_n = 1'b0;
        ticks(11);
        check("unf_evt", 32'(key_event), 32'h1);
        stream(16'hBEEF);
        check("unf_frz", 32'(frozen), 32'h0);
        check("unf_noload", 32'(nibbles), 32'h12AB);
        stream(16'hCAFE);
        check("unf_load", 32'(nibbles), 32'hCAFE);
        probe_valid = 1'b0;
        key_n = 1'b1;
        ticks(14);

        match_en    = 1'b1;
        match_value = 16'h0400;
        stream(16'h03FE);
        check("m_3fe", 32'(nibbles), 32'h03FE);
        stream(16'h03FF);
        check("m_3ff_frz", 32'(frozen), 32'h0);
        stream(16'h0400);
        check("m_hit_nib", 32'(nibbles), 32'h0400);
        check("m_hit_frz", 32'(frozen), 32'h1);
        stream(16'h0401);
        match_en = 1'b0;
        stream(16'h0401);
        match_en = 1'b1;
        stream(16'h0401);
        check("m_held_nib", 32'(nibbles), 32'h0400);
        check("m_held_frz", 32'(frozen), 32'h1);
        probe_valid = 1'b0;
        press_release();
        check("m_unf", 32'(frozen), 32'h0);

        match_en = 1'b0;
        stream(16'h03FE);
        stream(16'h03FF);
        stream(16'h0400);
        stream(16'h0401);
        check("nm_nib", 32'(nibbles), 32'h0401);
        check("nm_frz", 32'(frozen), 32'h0);
        probe_valid = 1'b0;

        match_en = 1'b1;
        key_n    = 1'b0;
        ticks(11);
        check("sim_evt", 32'(key_event), 32'h1);
        stream(16'h0400);
        check("sim_nib", 32'(nibbles), 32'h0400);
        check("sim_frz", 32'(frozen), 32'h1);
        probe_valid = 1'b0;
        key_n = 1'b1;
        ticks(14);
        press_release();
        check("sim_unf", 32'(frozen), 32'h0);
        key_n = 1'b0;
        ticks(11);
        stream(16'h1111);
        check("kev_frz", 32'(frozen), 32'h1);
        check("kev_noload", 32'(nibbles), 32'h0400);
        probe_valid = 1'b0;
        key_n = 1'b1;
        ticks(14);

        key_n = 1'b0;
        ticks(5);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_nib", 32'(nibbles), 32'h0);
        check("arst_frz", 32'(frozen), 32'h0);
        check("arst_evt", 32'(key_event), 32'h0);
        reset_n = 1'b1;
        events = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            events += int'(key_event);
        end
        check("arst_early", 32'(events), 32'h0);
        tick();
        check("arst_evt11", 32'(key_event), 32'h1);
        tick();
        check("arst_frz2", 32'(frozen), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
